// File: rtl/i_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : i_mem_responder_if
//  Purpose  : Instruction-cache refill port and loader port bundle for
//             i_mem_responder (master = cache/loader side, slave = memory).
//  Revision : 1.0  initial release
// ============================================================================
interface i_mem_responder_if #(
   parameter int A_WIDTH = 32,
   parameter int MEM_AW  = 12
);
   logic [A_WIDTH-1:0] m_a;
   logic               m_strobe;
   logic [31:0]        m_dout;
   logic               m_ready;
   logic               m_err;
   logic               ld_we;
   logic [MEM_AW-1:0]  ld_addr;
   logic [31:0]        ld_data;

   modport master (
      output m_a, m_strobe, ld_we, ld_addr, ld_data,
      input  m_dout, m_ready, m_err
   );

   modport slave (
      input  m_a, m_strobe, ld_we, ld_addr, ld_data,
      output m_dout, m_ready, m_err
   );
endinterface
`default_nettype wire

// File: rtl/i_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : i_mem_responder
//  Purpose  : Memory-side responder for the I-cache refill port: single-word
//             reads after WAIT_CYCLES wait states, with abort/redirect and a
//             loader write port. Optional macro IMEM_RANGE_CHECK_EN flags
//             requests whose upper address bits are non-zero.
//  Revision : 1.0  initial release
// ============================================================================
module i_mem_responder #(
   parameter int    A_WIDTH     = 32,
   parameter int    MEM_AW      = 12,
   parameter int    WAIT_CYCLES = 2,
   parameter string INIT_FILE   = ""
) (
   input wire               clk,
   input wire               rst,
   i_mem_responder_if.slave bus
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_wait = 2'd1;
   localparam logic [1:0] c_resp = 2'd2;
   localparam logic [3:0] c_last = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   logic [31:0]        mem [0:(1 << MEM_AW) - 1];

   logic [1:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [A_WIDTH-1:0] req_addr_q, req_addr_d;
   logic               m_ready_q, m_ready_d;
   logic               m_err_q, m_err_d;
   logic [31:0]        m_dout_q, m_dout_d;

   logic [MEM_AW-1:0]  w_word_idx;
   logic               w_oor;

   always_ff @(posedge clk) begin
      if (bus.ld_we) begin
         mem[bus.ld_addr] <= bus.ld_data;
      end
   end

   assign w_word_idx = req_addr_q[MEM_AW+1:2];

`ifdef IMEM_RANGE_CHECK_EN
   assign w_oor = |req_addr_q[A_WIDTH-1:MEM_AW+2];
`else
   assign w_oor = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= c_idle;
         cnt_q      <= 4'd0;
         req_addr_q <= '0;
         m_ready_q  <= 1'b0;
         m_err_q    <= 1'b0;
         m_dout_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_addr_q <= req_addr_d;
         m_ready_q  <= m_ready_d;
         m_err_q    <= m_err_d;
         m_dout_q   <= m_dout_d;
      end
   end

   // Abort and redirect are tested before the wait-count completion.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_addr_d = req_addr_q;
      case (state_q)
         c_idle: begin
            if (bus.m_strobe) begin
               req_addr_d = bus.m_a;
               cnt_d      = 4'd0;
               state_d    = (WAIT_CYCLES == 0) ? c_resp : c_wait;
            end
         end
         c_wait: begin
            if (!bus.m_strobe) begin
               state_d = c_idle;
            end else if (bus.m_a != req_addr_q) begin
               req_addr_d = bus.m_a;
               cnt_d      = 4'd0;
            end else if (cnt_q == c_last) begin
               state_d = c_resp;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         c_resp:  state_d = c_idle;
         default: state_d = c_idle;
      endcase
   end

   // The array is sampled only on the edge that raises m_ready, so a loader
   // write landing on that same edge is not visible in the response.
   always_comb begin
      m_ready_d = 1'b0;
      m_err_d   = 1'b0;
      m_dout_d  = m_dout_q;
      if (state_q == c_resp) begin
         m_ready_d = 1'b1;
         m_err_d   = w_oor;
         m_dout_d  = w_oor ? 32'd0 : mem[w_word_idx];
      end
   end

   assign bus.m_ready = m_ready_q;
   assign bus.m_err   = m_err_q;
   assign bus.m_dout  = m_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_i_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i_mem_responder
//  Purpose  : Directed self-checking bench for i_mem_responder with a
//             deadline-based transaction model checked every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i_mem_responder;

   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   i_mem_responder_if #(.A_WIDTH(32), .MEM_AW(12)) bus ();

   i_mem_responder #(
      .A_WIDTH(32), .MEM_AW(12), .WAIT_CYCLES(W), .INIT_FILE("")
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit mdl_oor(input logic [31:0] a);
`ifdef IMEM_RANGE_CHECK_EN
      return a[31:14] != 18'd0;
`else
      return 1'b0;
`endif
   endfunction

   // Transaction model: a pending request owns a deadline edge; redirect
   // moves the deadline, abort discards it, the deadline edge produces data.
   logic [31:0] mdl_mem [0:4095];
   logic        exp_ready = 1'b0;
   logic        exp_err   = 1'b0;
   logic [31:0] exp_dout  = 32'd0;
   bit          pend      = 1'b0;
   logic [31:0] raddr     = 32'd0;
   int          e         = 0;
   int          due       = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend      = 1'b0;
         exp_ready = 1'b0;
         exp_err   = 1'b0;
         exp_dout  = 32'd0;
         e         = 0;
      end else begin
         e++;
         exp_ready = 1'b0;
         exp_err   = 1'b0;
         if (pend && e == due) begin
            exp_ready = 1'b1;
            exp_err   = mdl_oor(raddr);
            exp_dout  = exp_err ? 32'd0 : mdl_mem[raddr[13:2]];
            pend      = 1'b0;
         end else if (pend) begin
            if (!bus.m_strobe) begin
               pend = 1'b0;
            end else if (bus.m_a != raddr) begin
               raddr = bus.m_a;
               due   = e + 1 + W;
            end
         end else if (bus.m_strobe) begin
            pend  = 1'b1;
            raddr = bus.m_a;
            due   = e + 1 + W;
         end
         if (bus.ld_we) mdl_mem[bus.ld_addr] = bus.ld_data;
      end
   end

   always @(negedge clk) begin
      chk("cyc m_ready", {31'd0, bus.m_ready}, {31'd0, exp_ready});
      chk("cyc m_err",   {31'd0, bus.m_err},   {31'd0, exp_err});
      chk("cyc m_dout",  bus.m_dout, exp_dout);
   end

   task automatic load(input logic [11:0] a, input logic [31:0] d);
      bus.ld_we   = 1'b1;
      bus.ld_addr = a;
      bus.ld_data = d;
      @(negedge clk);
      bus.ld_we   = 1'b0;
   endtask

   // k counts edges from the next one (k=0); -1 means no pulse within limit.
   task automatic wait_pulse(input int limit, output int k_out);
      k_out = -1;
      for (int k = 0; k < limit; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.m_ready) begin
            k_out = k;
            return;
         end
      end
   endtask

   int k;
   int n_rdy;

   initial begin
      bus.m_strobe = 1'b0;
      bus.m_a      = 32'd0;
      bus.ld_we    = 1'b0;
      bus.ld_addr  = 12'd0;
      bus.ld_data  = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset m_ready", {31'd0, bus.m_ready}, 32'd0);
      chk("reset m_dout",  bus.m_dout, 32'd0);
      chk("reset m_err",   {31'd0, bus.m_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      load(12'd4, 32'hDEADBEEF);
      load(12'd5, 32'h12345678);
      load(12'd0, 32'hA5A50000);

      // basic latency, then continuous strobe gives a pulse every 4 cycles
      bus.m_a = 32'h10; bus.m_strobe = 1'b1;
      wait_pulse(12, k);
      chk("latency edge", k, 3);
      chk("latency data", bus.m_dout, 32'hDEADBEEF);
      wait_pulse(12, k);
      chk("b2b spacing 1", k, 3);
      chk("b2b data 1", bus.m_dout, 32'hDEADBEEF);
      wait_pulse(12, k);
      chk("b2b spacing 2", k, 3);
      bus.m_strobe = 1'b0;
      repeat (2) @(negedge clk);
      chk("dout hold", bus.m_dout, 32'hDEADBEEF);

      // abort after one cycle, then a fresh request
      bus.m_a = 32'h10; bus.m_strobe = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.m_strobe = 1'b0;
      n_rdy = 0;
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         if (bus.m_ready) n_rdy++;
      end
      chk("abort no ready", n_rdy, 0);
      bus.m_a = 32'h14; bus.m_strobe = 1'b1;
      wait_pulse(12, k);
      chk("after abort edge", k, 3);
      chk("after abort data", bus.m_dout, 32'h12345678);
      bus.m_strobe = 1'b0;
      @(negedge clk);

      // redirect during WAIT
      bus.m_a = 32'h10; bus.m_strobe = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.m_a = 32'h14;
      wait_pulse(12, k);
      chk("redirect edge", k, 3);
      chk("redirect data", bus.m_dout, 32'h12345678);
      bus.m_strobe = 1'b0;
      @(negedge clk);

      // loader write during WAIT is returned
      bus.m_a = 32'h10; bus.m_strobe = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.ld_we = 1'b1; bus.ld_addr = 12'd4; bus.ld_data = 32'hCAFEF00D;
      @(posedge clk); @(negedge clk);
      bus.ld_we = 1'b0;
      wait_pulse(12, k);
      chk("ld race edge", k, 1);
      chk("ld race data", bus.m_dout, 32'hCAFEF00D);
      bus.m_strobe = 1'b0;
      @(negedge clk);

      // loader write on the response edge is not returned
      bus.m_a = 32'h14; bus.m_strobe = 1'b1;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
      end
      bus.ld_we = 1'b1; bus.ld_addr = 12'd5; bus.ld_data = 32'hBBBB0001;
      @(posedge clk); @(negedge clk);
      bus.ld_we = 1'b0;
      chk("resp edge ready", {31'd0, bus.m_ready}, 32'd1);
      chk("resp edge old data", bus.m_dout, 32'h12345678);
      bus.m_strobe = 1'b0;
      @(negedge clk);
      bus.m_strobe = 1'b1;
      wait_pulse(12, k);
      chk("new data edge", k, 3);
      chk("new data", bus.m_dout, 32'hBBBB0001);
      bus.m_strobe = 1'b0;
      @(negedge clk);

      // asynchronous reset in the middle of WAIT
      bus.m_a = 32'h10; bus.m_strobe = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst m_ready", {31'd0, bus.m_ready}, 32'd0);
      chk("async rst m_dout",  bus.m_dout, 32'd0);
      chk("async rst m_err",   {31'd0, bus.m_err}, 32'd0);
      bus.m_strobe = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus.m_strobe = 1'b1;
      wait_pulse(12, k);
      chk("post rst edge", k, 3);
      chk("post rst data", bus.m_dout, 32'hCAFEF00D);
      bus.m_strobe = 1'b0;
      @(negedge clk);

      // upper address bits set
      bus.m_a = 32'h0000_4000; bus.m_strobe = 1'b1;
      wait_pulse(12, k);
      chk("upper addr edge", k, 3);
`ifdef IMEM_RANGE_CHECK_EN
      chk("upper addr data", bus.m_dout, 32'd0);
      chk("upper addr err", {31'd0, bus.m_err}, 32'd1);
`else
      chk("upper addr data", bus.m_dout, 32'hA5A50000);
      chk("upper addr err", {31'd0, bus.m_err}, 32'd0);
`endif
      bus.m_strobe = 1'b0;
      repeat (3) @(negedge clk);
      chk("err cleared", {31'd0, bus.m_err}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
